// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write handshake, serial line and status bundle for uart_tx_fifo
// master drives wr_data/wr_valid and observes the rest; slave is the transmitter side
interface uart_tx_fifo_if #(
  parameter int NUM_DATA_BITS = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [NUM_DATA_BITS-1:0] wr_data;
  logic wr_valid;
  logic wr_ready;
  logic tx;
  logic busy;
  logic tx_done;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master(output wr_data, wr_valid, input wr_ready, tx, busy, tx_done, fifo_count);
  modport slave(input wr_data, wr_valid, output wr_ready, tx, busy, tx_done, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data bits, parity and stop bits
// clk/rst: system clock, asynchronous active-high reset
// bus.wr_data/wr_valid/wr_ready: FIFO write handshake; bus.tx: serial line (idle high)
// bus.busy: frame in progress; bus.tx_done: one-cycle end-of-frame pulse; bus.fifo_count: words queued
module uart_tx_fifo #(
  parameter int FREQUENCY_IN_HZ = 100_000_000,
  parameter int BAUD = 115200,
  parameter int NUM_DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  uart_tx_fifo_if.slave bus
);
  localparam int B = FREQUENCY_IN_HZ / BAUD;
  localparam int BW = $clog2(B);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;
  logic [NUM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [2:0] state;
  logic [BW-1:0] cnt;
  logic [3:0] bidx;
  logic [NUM_DATA_BITS-1:0] sh, head;
  logic par, tx_q, done_q, tick, stop_end, push, pop;
  assign head = mem[rptr];
  assign tick = cnt == BW'(B - 1);
  assign stop_end = state == S_STOP && tick && bidx == 4'(STOP_BITS - 1);
  assign push = bus.wr_valid && bus.wr_ready;
  // a new frame is loaded either from idle or straight out of the last stop bit
  assign pop = (state == S_IDLE || stop_end) && count != '0;
  assign bus.wr_ready = count != CW'(FIFO_DEPTH);
  assign bus.fifo_count = count;
  assign bus.tx = tx_q;
  assign bus.busy = state != S_IDLE;
  assign bus.tx_done = done_q;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= bus.wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      bidx <= '0;
      sh <= '0;
      par <= 1'b0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= stop_end;
      cnt <= (state == S_IDLE || tick) ? '0 : cnt + BW'(1);
      if (pop) begin
        sh <= head;
        par <= (PARITY == 2) ? ^head : ~^head;
        state <= S_START;
        tx_q <= 1'b0;
      end else begin
        case (state)
          S_START:
            if (tick) begin
              state <= S_DATA;
              tx_q <= sh[0];
              bidx <= '0;
            end
          S_DATA:
            if (tick) begin
              sh <= sh >> 1;
              if (bidx == 4'(NUM_DATA_BITS - 1)) begin
                state <= (PARITY != 0) ? S_PAR : S_STOP;
                tx_q <= (PARITY != 0) ? par : 1'b1;
                bidx <= '0;
              end else begin
                bidx <= bidx + 4'd1;
                tx_q <= sh[1];
              end
            end
          S_PAR:
            if (tick) begin
              state <= S_STOP;
              tx_q <= 1'b1;
              bidx <= '0;
            end
          S_STOP:
            if (stop_end) begin
              state <= S_IDLE;
              tx_q <= 1'b1;
            end else if (tick) bidx <= bidx + 4'd1;
          default: begin
            state <= S_IDLE;
            tx_q <= 1'b1;
          end
        endcase
      end
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. Serialises words of configurable width, optional parity and one or two stop bits, at a bit period derived from the system clock frequency and baud rate. Sits between the core's memory-mapped I/O path and the board TX pin. Generalises the fixed 8N1 100 MHz / 115200 configuration to any frame format, and buffers writes so the core does not stall per character.

## Interface
- FREQUENCY_IN_HZ, 100_000_000, system clock frequency
- BAUD, 115200, line rate; bit period B = FREQUENCY_IN_HZ / BAUD (integer truncation), B ≥ 2 required
- NUM_DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, entries, power of two, ≥ 2

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_data  in  NUM_DATA_BITS  word to transmit
- wr_valid  in  1  write request
- wr_ready  out  1  FIFO not full; word accepted on an edge where wr_valid && wr_ready
- tx  out  1  serial line, idle high, registered
- busy  out  1  FSM not in IDLE
- tx_done  out  1  one-cycle pulse after the last stop bit of each frame
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO

## Operation
- Reset values: tx=1, busy=0, tx_done=0, wr_ready=1, fifo_count=0; FSM in IDLE; FIFO pointers cleared.
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH. wr_ready = (fifo_count != FIFO_DEPTH). A write while full is ignored; no data is corrupted. Simultaneous push and pop leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If fifo_count>0, pop the head into the shift register and go to START.
  - START: tx=0 for B cycles, then DATA.
  - DATA: bits sent LSB first, B cycles each. A bit index counts 0..NUM_DATA_BITS-1. After the last bit, go to PARITY if PARITY≠0, else STOP.
  - PARITY: tx = ^data (even) or ~^data (odd) for B cycles. Parity is computed over the popped word.
  - STOP: tx=1 for STOP_BITS×B cycles. At the end, pulse tx_done. If fifo_count>0, pop and go directly to START, with no idle cycle. Otherwise go to IDLE.
- Baud counter: counts 0..B-1, reloads at each bit boundary, and is held at 0 in IDLE.
- Frame length: B×(1+NUM_DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- wr_data sampled into the FIFO is unaffected by later changes on the input.

## Timing
- Write accepted at edge N (FIFO empty, FSM IDLE):
  - fifo_count=1 after edge N.
  - At edge N+1: pop, enter START, tx=0, busy=1, fifo_count=0.
- Each tx level holds for exactly B cycles. Stop holds for STOP_BITS×B cycles.
- tx_done is high for the single cycle following the final stop-bit cycle, concurrent with tx=0 of the next START or with IDLE.
- Pop in STOP→START and a write on the same edge: fifo_count unchanged, both take effect.
- Reset asserted mid-frame:
  - tx→1 and busy→0 immediately (asynchronous).
  - FIFO contents are discarded.
  - After release, the first frame starts only on a new write.
- wr_ready deasserts in the cycle after the write that fills the FIFO. It reasserts in the cycle after a pop.

## Test plan
Test parameters: FREQUENCY_IN_HZ=40, BAUD=10, so B=4.

- **8N1 single frame.** Write 0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles. tx_done pulses once, 40 cycles after START began. busy=0 afterwards.
- **Even and odd parity (PARITY=2, then 1).** Write 0x07 -> parity bit 1 (even), 0 (odd). Frame is 44 cycles.
- **Two stop bits, NUM_DATA_BITS=5.** Write 0x1F -> 5 data bits high, stop high for 8 cycles, frame 32 cycles. The upper wr_data bits are ignored.
- **Back-to-back and full.** FIFO_DEPTH=4. Write 6 words on consecutive cycles:
  - Word 1 pops at once, then 4 more are accepted; wr_ready=0 on the 6th, so it is dropped.
  - 5 frames are sent with no idle cycle between them; fifo_count decrements at each START.
- **Simultaneous push/pop.** Issue a write on the exact edge of a STOP→START transition -> fifo_count unchanged, the word is transmitted in order.
- **Reset mid-frame.** Assert rst during DATA bit 3 with 2 words queued -> tx=1 and busy=0 asynchronously, fifo_count=0. No frame follows until a new write.
